// File: rtl/fetch_aligner.sv
// rtl/fetch_aligner.sv - instruction fetch and halfword realignment buffer; RV32C support under FETCH_ALIGNER_COMPRESSED_EN
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_compressed
);

`ifdef FETCH_ALIGNER_COMPRESSED_EN
  localparam bit COMP_EN = 1'b1;
`else
  localparam bit COMP_EN = 1'b0;
`endif

  // Without compressed support every PC is word aligned, so bit 1 is dropped too.
  localparam logic [31:0] PC_MASK = COMP_EN ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;

  // Halfword FIFO packed into one vector: entry 0 (oldest) in bits [15:0].
  // Bits above cnt halfwords are kept at zero so a push can simply OR in.
  logic [63:0] hw_q;
  logic [2:0]  cnt;
  logic [31:0] head_pc;
  logic [31:0] fetch_addr;
  logic        drop_hi;

  logic [15:0] h0;
  logic [15:0] h1;
  logic        is_comp;
  logic        inst_valid;
  logic        pop;
  logic        ack;
  logic [2:0]  pop_n;
  logic [2:0]  cnt_after_pop;
  logic [2:0]  push_n;
  logic [31:0] push_data;
  logic [63:0] hw_next;

  assign h0 = hw_q[15:0];
  assign h1 = hw_q[31:16];

  // Head decode, pop/push sizing, request generation and next buffer image
  always_comb begin
    is_comp       = COMP_EN && (h0[1:0] != 2'b11);
    inst_valid    = is_comp ? (cnt >= 3'd1) : (cnt >= 3'd2);
    pop           = inst_valid & i_inst_ready & ~i_redirect;
    pop_n         = !pop ? 3'd0 : (is_comp ? 3'd1 : 3'd2);
    cnt_after_pop = cnt - pop_n;
    o_mem_req     = i_rst_n & (cnt_after_pop <= 3'd2) & ~i_redirect;
    ack           = i_mem_ack & o_mem_req;
    if (drop_hi) begin
      push_data = {16'h0000, i_mem_rdata[31:16]};
      push_n    = ack ? 3'd1 : 3'd0;
    end else begin
      push_data = i_mem_rdata;
      push_n    = ack ? 3'd2 : 3'd0;
    end
    hw_next = hw_q >> {pop_n, 4'b0000};
    if (ack) begin
      hw_next = hw_next | ({32'h0000_0000, push_data} << {cnt_after_pop, 4'b0000});
    end
  end

  assign o_mem_addr   = fetch_addr;
  assign o_inst_valid = inst_valid;
  assign o_compressed = inst_valid & is_comp;
  assign o_inst       = !inst_valid ? 32'h0 : (is_comp ? {16'h0000, h0} : {h1, h0});
  assign o_inst_pc    = inst_valid ? head_pc : 32'h0;

  // Buffer, count and PC state; a redirect flushes and overrides ack and pop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hw_q       <= 64'h0;
      cnt        <= 3'd0;
      head_pc    <= RESET_PC & PC_MASK;
      fetch_addr <= {RESET_PC[31:2], 2'b00};
    end else if (i_redirect) begin
      hw_q       <= 64'h0;
      cnt        <= 3'd0;
      head_pc    <= i_redirect_pc & PC_MASK;
      fetch_addr <= {i_redirect_pc[31:2], 2'b00};
    end else begin
      hw_q    <= hw_next;
      cnt     <= cnt_after_pop + push_n;
      head_pc <= head_pc + {28'h0, pop_n, 1'b0};
      if (ack) begin
        fetch_addr <= fetch_addr + 32'd4;
      end
    end
  end

`ifdef FETCH_ALIGNER_COMPRESSED_EN
  // A halfword-offset target skips the low half of the first fetched word
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      drop_hi <= RESET_PC[1];
    end else if (i_redirect) begin
      drop_hi <= i_redirect_pc[1];
    end else if (ack) begin
      drop_hi <= 1'b0;
    end
  end
`else
  assign drop_hi = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_aligner.sv
// tb/tb_fetch_aligner.sv - directed bench for fetch_aligner
module tb_fetch_aligner;

  localparam logic [31:0] RPC = 32'h0000_0100;
`ifdef FETCH_ALIGNER_COMPRESSED_EN
  localparam logic [31:0] REDIR_PC  = 32'h0000_0202;
  localparam logic [31:0] REDIR_INS = 32'h0000_1234;
  localparam logic [31:0] REDIR_CMP = 32'h1;
`else
  localparam logic [31:0] REDIR_PC  = 32'h0000_0200;
  localparam logic [31:0] REDIR_INS = 32'h1234_4501;
  localparam logic [31:0] REDIR_CMP = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        compressed;
  logic        mem_en;
  logic        force_ack;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0093_4505;
      32'h0000_0004: return 32'h4605_0050;
      32'h0000_0100: return 32'h0050_0093;
      32'h0000_0104: return 32'h00A0_0113;
      32'h0000_0200: return 32'h1234_4501;
      default:       return {a[21:2], 12'h013};
    endcase
  endfunction

  assign mem_rdata = word_at(mem_addr);
  assign mem_ack   = force_ack | (mem_en & mem_req);

  fetch_aligner #(.RESET_PC(RPC)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_mem_req     (mem_req),
    .o_mem_addr    (mem_addr),
    .i_mem_ack     (mem_ack),
    .i_mem_rdata   (mem_rdata),
    .o_inst_valid  (inst_valid),
    .i_inst_ready  (inst_ready),
    .o_inst        (inst),
    .o_inst_pc     (inst_pc),
    .o_compressed  (compressed)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk_inst(input string tag, input logic [31:0] ei, input logic [31:0] epc,
                          input logic [31:0] ec);
    chk({tag, "_valid"}, {31'h0, inst_valid}, 32'h1);
    chk({tag, "_inst"}, inst, ei);
    chk({tag, "_pc"}, inst_pc, epc);
    chk({tag, "_comp"}, {31'h0, compressed}, ec);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"}, {31'h0, mem_req}, 32'h0);
    chk({tag, "_valid"}, {31'h0, inst_valid}, 32'h0);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_pc"}, inst_pc, 32'h0);
    chk({tag, "_comp"}, {31'h0, compressed}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    inst_ready = 1'b0; mem_en = 1'b0; force_ack = 1'b0;

    // reset state
    sample();
    chk_idle_outputs("rst");

    // sequential fetch with same-cycle ack
    advance(); rst_n = 1'b1; mem_en = 1'b1; inst_ready = 1'b1;
    sample();
    chk("rel_req", {31'h0, mem_req}, 32'h1);
    chk("rel_addr", mem_addr, 32'h100);
    chk("rel_valid", {31'h0, inst_valid}, 32'h0);
    advance(); sample();
    chk_inst("seq0", 32'h0050_0093, 32'h100, 32'h0);
    chk("seq0_addr", mem_addr, 32'h104);
    advance(); sample();
    chk_inst("seq1", 32'h00A0_0113, 32'h104, 32'h0);
    chk("seq1_addr", mem_addr, 32'h108);

    // backpressure: buffer fills, then req drops and head holds
    advance(); inst_ready = 1'b0;
    sample();
    chk_inst("bp_first", word_at(32'h108), 32'h108, 32'h0);
    chk("bp_first_req", {31'h0, mem_req}, 32'h1);
    chk("bp_first_addr", mem_addr, 32'h10C);
    for (int i = 0; i < 10; i++) begin
      advance(); sample();
      chk("bp_req", {31'h0, mem_req}, 32'h0);
      chk("bp_hold_inst", inst, word_at(32'h108));
      chk("bp_hold_pc", inst_pc, 32'h108);
    end
    advance(); inst_ready = 1'b1;
    sample();
    chk_inst("bp_rel", word_at(32'h108), 32'h108, 32'h0);
    chk("bp_rel_req", {31'h0, mem_req}, 32'h1);
    chk("bp_rel_addr", mem_addr, 32'h110);
    for (int k = 1; k <= 3; k++) begin
      advance(); sample();
      chk_inst("bp_drain", word_at(32'h108 + 32'(4 * k)), 32'h108 + 32'(4 * k), 32'h0);
    end

    // redirect with a full buffer
    advance(); inst_ready = 1'b0;
    sample();
    chk_inst("pre_redir", word_at(32'h118), 32'h118, 32'h0);
    chk("pre_redir_req", {31'h0, mem_req}, 32'h0);
    advance(); redirect = 1'b1; redirect_pc = 32'h202; inst_ready = 1'b1;
    sample();
    chk("redir_req", {31'h0, mem_req}, 32'h0);
    chk_inst("redir_head", word_at(32'h118), 32'h118, 32'h0);
    advance(); redirect = 1'b0;
    sample();
    chk("redir_next_req", {31'h0, mem_req}, 32'h1);
    chk("redir_next_addr", mem_addr, 32'h200);
    chk("redir_next_valid", {31'h0, inst_valid}, 32'h0);
    advance(); sample();
    chk_inst("redir_first", REDIR_INS, REDIR_PC, REDIR_CMP);
    advance(); sample();
    chk_inst("redir_second", word_at(32'h204), 32'h204, 32'h0);

    // redirect, forced ack and pop in one cycle
    advance(); redirect = 1'b1; redirect_pc = 32'h300; force_ack = 1'b1;
    sample();
    chk_inst("sim_head", word_at(32'h208), 32'h208, 32'h0);
    advance(); redirect = 1'b0; force_ack = 1'b0;
    sample();
    chk("sim_valid", {31'h0, inst_valid}, 32'h0);
    chk("sim_req", {31'h0, mem_req}, 32'h1);
    chk("sim_addr", mem_addr, 32'h300);
    advance(); sample();
    chk_inst("sim_first", word_at(32'h300), 32'h300, 32'h0);
    advance(); sample();
    chk_inst("sim_second", word_at(32'h304), 32'h304, 32'h0);

    // asynchronous reset while a request is pending
    advance(); inst_ready = 1'b0; mem_en = 1'b0;
    sample();
    chk_inst("ar_pre", word_at(32'h308), 32'h308, 32'h0);
    chk("ar_pre_req", {31'h0, mem_req}, 32'h1);
    chk("ar_pre_addr", mem_addr, 32'h30C);
    #2; rst_n = 1'b0;
    #1;
    chk_idle_outputs("ar_now");
    advance();
    advance(); rst_n = 1'b1;
    sample();
    chk("ar_rel_req", {31'h0, mem_req}, 32'h1);
    chk("ar_rel_addr", mem_addr, RPC);
    chk("ar_rel_valid", {31'h0, inst_valid}, 32'h0);

`ifdef FETCH_ALIGNER_COMPRESSED_EN
    // mixed compressed and straddling instructions from 0x0
    advance(); redirect = 1'b1; redirect_pc = 32'h0;
    sample();
    advance(); redirect = 1'b0; mem_en = 1'b1; inst_ready = 1'b1;
    sample();
    chk("mix_addr", mem_addr, 32'h0);
    advance(); sample();
    chk_inst("mix0", 32'h0000_4505, 32'h0, 32'h1);
    advance(); sample();
    chk_inst("mix1", 32'h0050_0093, 32'h2, 32'h0);
    advance(); sample();
    chk_inst("mix2", 32'h0000_4605, 32'h6, 32'h1);

    // partial 32-bit instruction waits for its upper half
    advance(); redirect = 1'b1; redirect_pc = 32'h2;
    sample();
    advance(); redirect = 1'b0;
    sample();
    chk("part_addr0", mem_addr, 32'h0);
    advance(); mem_en = 1'b0;
    sample();
    chk("part_wait_valid", {31'h0, inst_valid}, 32'h0);
    chk("part_wait_addr", mem_addr, 32'h4);
    advance(); mem_en = 1'b1;
    sample();
    chk("part_wait2_valid", {31'h0, inst_valid}, 32'h0);
    advance(); sample();
    chk_inst("part_done", 32'h0050_0093, 32'h2, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_aligner.md
# fetch_aligner

Instruction fetch and realignment buffer that feeds the instruction decoder. It reads word-aligned 32-bit words from instruction memory through a request/acknowledge port and buffers them as halfwords. It emits one aligned instruction per handshake, either a 16-bit compressed instruction or a 32-bit instruction, including 32-bit instructions that straddle a word boundary. It also handles PC redirects from branches and jumps, including targets at halfword offsets.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC after reset; bits [0] must be 0.

- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_redirect  input  1  flush and restart fetch at i_redirect_pc.
- i_redirect_pc  input  32  redirect target; bit [0] is ignored (treated as 0).
- o_mem_req  output  1  memory read request.
- o_mem_addr  output  32  word address of the request; bits [1:0] are always 0.
- i_mem_ack  input  1  read complete; valid only while o_mem_req=1.
- i_mem_rdata  input  32  read data, valid in the i_mem_ack cycle.
- o_inst_valid  output  1  o_inst, o_inst_pc and o_compressed are valid.
- i_inst_ready  input  1  decoder accepts the instruction.
- o_inst  output  32  instruction; when compressed, [15:0] holds the instruction and [31:16] is 0.
- o_inst_pc  output  32  PC of o_inst.
- o_compressed  output  1  o_inst is 16-bit (bits [1:0] != 2'b11).

## Operation
- **Buffer:** 4 halfword entries (64 bits) in FIFO order, with halfword count `cnt` (0..4). Registers: `head_pc`, `fetch_addr`, `drop_hi` flag.
- **Head decode:** let h0 and h1 be the first and second buffered halfwords.
  - Compressed when h0[1:0] != 2'b11.
  - o_inst_valid = (cnt>=1 & compressed) | (cnt>=2 & !compressed).
  - o_inst = {16'h0,h0} if compressed, {h1,h0} otherwise.
  - o_inst, o_compressed and o_inst_pc (= head_pc) are forced to 0 when o_inst_valid=0.
- **Pop:** a pop occurs when o_inst_valid & i_inst_ready. It removes 1 or 2 halfwords and advances head_pc by 2 or 4.
- **Fetch:**
  - o_mem_req = (cnt_after_pop <= 2) & !i_redirect, with o_mem_addr = fetch_addr.
  - On ack, fetch_addr += 4 and the word is pushed at the tail: low halfword first, then high.
  - If drop_hi is set, only i_mem_rdata[31:16] is pushed and drop_hi is cleared.
  - A simultaneous push and pop in one cycle is legal: cnt_next = cnt − popped + pushed.
- **Memory protocol:** o_mem_req may deassert without an ack (request abandoned). Memory must not ack when req=0.
- **Redirect** (highest priority; overrides ack and pop in the same cycle):
  - cnt←0, head_pc←{pc[31:1],1'b0}, fetch_addr←{pc[31:2],2'b00}, drop_hi←pc[1].
  - Ack data in the redirect cycle is discarded.
  - The instruction presented in the redirect cycle is not considered consumed, even if i_inst_ready=1.
- **Reset:**
  - cnt=0, head_pc=RESET_PC, fetch_addr={RESET_PC[31:2],2'b00}, drop_hi=RESET_PC[1], buffer=0.
  - Outputs during reset: o_mem_req=0 (gated while i_rst_n=0), o_inst_valid=0, o_inst=0, o_inst_pc=0, o_compressed=0.
  - Reset mid-request abandons the request.
- **Partial 32-bit instruction:** a 32-bit instruction whose h0 is the last buffered halfword waits, with valid=0, until the next word arrives.

## Timing
- Outputs o_inst*, o_compressed and o_inst_valid are combinational from registered buffer state. o_mem_req is combinational from cnt, pop and i_redirect. There is no combinational path from i_mem_rdata to outputs.
- Fetch-to-issue latency: ack in cycle N, so o_inst_valid is 1 in cycle N+1 (if the head instruction is complete).
- Redirect latency: i_redirect in cycle N, so o_mem_req=1 with the new address in cycle N+1. The first instruction is valid no earlier than the cycle after its ack.
- After reset release: o_mem_req=1 in the first cycle with i_rst_n=1.
- Throughput with single-cycle ack: one 32-bit instruction per cycle is sustained. The buffer never overflows because req requires cnt_after_pop<=2.

## Configuration
- FETCH_ALIGNER_COMPRESSED_EN defined: full RV32C support as described above.
- FETCH_ALIGNER_COMPRESSED_EN undefined:
  - Every instruction is treated as 32-bit.
  - o_compressed is tied to 0.
  - i_redirect_pc[1] and RESET_PC[1] are ignored, and drop_hi is removed.
  - The buffer shrinks to 2 words; req = cnt_after_pop <= 2 still applies.
  - o_inst = {h1,h0} whenever cnt>=2.

## Test plan
- **Reset and sequential fetch:** RESET_PC=0x100; memory acks every request in the same cycle with words 0x00500093 and 0x00A00113; ready=1. Expect o_mem_addr 0x100, 0x104, and o_inst 0x00500093 @pc 0x100, then 0x00A00113 @pc 0x104, with o_compressed=0.
- **Mixed compressed:** word@0x0 = 0x0093_4505 (c.li a0,1 low; 32-bit low half high), word@0x4 = 0x4605_0050. Expect o_inst 0x00004505 @0x0 with compressed=1. Then 0x00500093 @0x2 (straddling). Then 0x00004605 @0x6.
- **Redirect to halfword target:** redirect to 0x202 while 2 words are buffered. Next cycle: o_mem_addr=0x200, cnt=0. Word 0x1234_4501 yields o_inst 0x00001234 @0x202 only; the low half is dropped.
- **Backpressure:** ready=0 for 10 cycles. Expect req to deassert once cnt>=3, no overflow, and o_inst held stable. Releasing ready yields instructions in order with no gaps or duplicates.
- **Simultaneous redirect, ack and pop:** all three in one cycle. Expect ack data discarded, head instruction not counted as consumed, and the new PC fetched next cycle.
- **Async reset mid-request:** assert i_rst_n=0 while req is pending with no ack. Outputs go to 0 immediately. After release, o_mem_addr=RESET_PC.
